// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator for the heater and fan drivers.
//
// A shared prescaler produces a tick every prescale+1 clk cycles. A shared
// counter advances on each tick over 0..period. Channel i's raw output is
// (counter < duty_i), XORed with invert[i] and registered.
//
// Runtime changes go through a shadow set:
//   - update captures prescale/period/duty/invert into the shadow set.
//   - On the next wrap, the shadow set is copied into the active set.
// This keeps every period glitch-free. While disabled, the active set
// tracks the inputs directly.
//
// Ports:
//   clk           system clock
//   rstN          asynchronous active-low reset
//   enable        run control; low holds counters at 0, outputs inactive
//   prescale      tick every prescale+1 clk cycles
//   period        counter runs 0..period
//   duty          packed per-channel duty, channel i at [i*DataWidth +: DataWidth]
//   invert        per-channel polarity, 1 = active-low
//   update        one-cycle request to capture inputs into the shadow set
//   pwm           registered PWM outputs
//   period_start  pulse on the clk where the counter wraps to 0
//   update_ack    pulse on the clk where the shadow set becomes active
module pwm_multi #(
  parameter int DataWidth     = 10,
  parameter int NumChannels   = 4,
  parameter int PrescaleWidth = 8
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             enable,
  input  logic [PrescaleWidth-1:0]         prescale,
  input  logic [DataWidth-1:0]             period,
  input  logic [NumChannels*DataWidth-1:0] duty,
  input  logic [NumChannels-1:0]           invert,
  input  logic                             update,
  output logic [NumChannels-1:0]           pwm,
  output logic                             period_start,
  output logic                             update_ack
);

  localparam logic [PrescaleWidth-1:0] PcntOne = 1;
  localparam logic [DataWidth-1:0]     CntOne  = 1;

  logic [PrescaleWidth-1:0]         pcnt;
  logic [DataWidth-1:0]             counter;

  logic [PrescaleWidth-1:0]         act_prescale;
  logic [DataWidth-1:0]             act_period;
  logic [NumChannels*DataWidth-1:0] act_duty;
  logic [NumChannels-1:0]           act_invert;

  logic [PrescaleWidth-1:0]         sh_prescale;
  logic [DataWidth-1:0]             sh_period;
  logic [NumChannels*DataWidth-1:0] sh_duty;
  logic [NumChannels-1:0]           sh_invert;
  logic                             pending;

  logic                             tick;
  logic                             wrap;
  logic                             apply;
  logic [NumChannels-1:0]           raw;

  assign tick  = (pcnt == act_prescale);
  assign wrap  = tick && (counter == act_period);
  assign apply = wrap && pending;

  // Unsigned compare: duty 0 never drives, duty > period always drives.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NumChannels; i++) begin
      raw[i] = (counter < act_duty[i*DataWidth +: DataWidth]);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pcnt         <= '0;
      counter      <= '0;
      act_prescale <= '0;
      act_period   <= '0;
      act_duty     <= '0;
      act_invert   <= '0;
      sh_prescale  <= '0;
      sh_period    <= '0;
      sh_duty      <= '0;
      sh_invert    <= '0;
      pending      <= 1'b0;
      pwm          <= '0;
      period_start <= 1'b0;
      update_ack   <= 1'b0;
    end else if (!enable) begin
      // Stopped: active set follows the inputs, so the first enabled
      // period uses whatever was presented in the last disabled clk.
      pcnt         <= '0;
      counter      <= '0;
      act_prescale <= prescale;
      act_period   <= period;
      act_duty     <= duty;
      act_invert   <= invert;
      pending      <= 1'b0;
      pwm          <= invert;
      period_start <= 1'b0;
      update_ack   <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PcntOne;

      if (wrap) begin
        counter <= '0;
      end else if (tick) begin
        counter <= counter + CntOne;
      end

      period_start <= wrap;
      update_ack   <= apply;

      if (apply) begin
        act_prescale <= sh_prescale;
        act_period   <= sh_period;
        act_duty     <= sh_duty;
        act_invert   <= sh_invert;
      end

      // A capture in the apply clk refills the shadow set after the
      // old contents move to the active set. Pending stays set for the
      // next wrap.
      if (update) begin
        sh_prescale <= prescale;
        sh_period   <= period;
        sh_duty     <= duty;
        sh_invert   <= invert;
        pending     <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      pwm <= raw ^ act_invert;
    end
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator for the thermal block's heater and fan drivers.
- Parametrised channel count and resolution; programmable period and clock prescaler.
- Per-channel duty with glitch-free shadow update applied only at period boundaries, plus per-channel output polarity.
- Sits between the control-loop register interface and the power-stage gate drivers.

Parameters:
DataWidth, 10, width of period/duty/counter
NumChannels, 4, number of independent PWM outputs
PrescaleWidth, 8, width of prescaler divide value

Ports:
clk  in  1  system clock
rstN  in  1  asynchronous active-low reset
enable  in  1  run control; low = stopped, outputs inactive
prescale  in  PrescaleWidth  tick every prescale+1 clk cycles
period  in  DataWidth  counter runs 0..period (period+1 ticks per PWM cycle)
duty  in  NumChannels*DataWidth  channel i duty at [i*DataWidth +: DataWidth], in ticks
invert  in  NumChannels  per-channel polarity; 1 = active-low output
update  in  1  one-cycle request to capture prescale/period/duty/invert into shadow
pwm  out  NumChannels  registered PWM outputs
period_start  out  1  one-cycle pulse on the clk where counter loads 0 from wrap
update_ack  out  1  one-cycle pulse when shadow values become active

Behaviour:
- Reset (rstN low, asynchronous): prescaler count, counter, active and shadow registers, and pending flag cleared. pwm, period_start and update_ack are 0.
- Prescaler: pcnt counts 0..active prescale. tick = (pcnt == active prescale), and pcnt returns to 0 on tick. prescale=0 gives tick every clk.
- Counter: advances on tick. At counter == active period with a tick, counter wraps to 0 and period_start pulses on that clk. period=0 gives a wrap on every tick.
- Compare: raw_i = (counter < active duty_i), using unsigned DataWidth compare.
  - duty_i = 0: raw_i is always 0.
  - duty_i > period: raw_i is always 1 (100%).
- Output: pwm[i] <= raw_i XOR active invert[i]. pwm is registered, 1 clk after the counter value it reflects.
- Shadow update:
  - update=1 while enable=1 captures all inputs into shadow and sets pending.
  - A further update before apply overwrites the shadow; last write wins, and only one ack is produced.
  - Apply happens on the wrap tick with pending set: shadow is copied to active, pending is cleared, and update_ack pulses that same clk.
  - Active values are never changed mid-period while enable=1.
- Enable low:
  - pcnt and counter held at 0.
  - Active registers load directly from the inputs every clk.
  - pending cleared; update ignored; period_start and update_ack held at 0.
  - pwm[i] driven to the inactive level (= invert[i] input), registered.
- Enable rising:
  - First counter value is 0 with the values captured in the last disabled clk.
  - First tick occurs after prescale+1 clks.
  - No period_start pulse at start; the first pulse is at the first wrap.
- Simultaneous update and apply-wrap in the same clk:
  - The pending shadow is applied.
  - The new inputs are captured into shadow, and pending remains set for the next wrap.
- Reset mid-period: immediate return to the reset state; outputs 0 regardless of invert, until enable.

Test Plan:
- Reset then enable, prescale=0, period=9, duty0=3, invert=0 -> pwm[0] high 3 clks, low 7, repeating. period_start every 10 clks.
- prescale=3, period=4, duty1=2 -> pwm[1] high 8 clks, low 12. period_start every 20 clks.
- Running duty0=3, period=9; pulse update with duty0=7 at counter=4 -> remainder of the current period still uses 3. update_ack coincides with the next period_start; the next period is high 7.
- Boundaries: duty2=0 -> constant 0. duty3=10 with period=9 -> constant 1. period=0, duty=1 -> constant 1 and period_start every tick.
- invert=4'b0101, enable=0 -> pwm=4'b0101. Enable, duty0=3, period=9 -> pwm[0] low 3 / high 7.
- Two update pulses 2 clks apart within one period, then assert rstN=0 mid-period on a later run -> single update_ack applying second values. On reset: pwm=0, counter 0 immediately, no ack.
